// File: rtl/qtree_search.sv
// FANOUT-ary search tree: STAGES key levels route a lookup to a leaf bucket, whose entries are then compared.
// Latency STAGES+2 cycles at one lookup per cycle; a stalled result (res_valid_o && !res_ready_i) freezes every stage.
module qtree_search #(
  parameter int STAGES  = 3,
  parameter int FANOUT  = 4,
  parameter int D_WIDTH = 16,
  parameter int D_CNT   = 4,
  localparam int FW     = $clog2(FANOUT),
  localparam int DW     = $clog2(D_CNT),
  localparam int LA_W   = STAGES * FW,
  localparam int RA_W   = LA_W + DW,
  localparam int SEL_W  = $clog2(STAGES + 1),
  localparam int IDX_W  = (FW > DW) ? FW : DW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lookup_valid_i,
  output logic               lookup_ready_o,
  input  logic [D_WIDTH-1:0] lookup_data_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic               res_match_o,
  output logic [RA_W-1:0]    res_addr_o,
  output logic [D_WIDTH-1:0] res_data_o,
  input  logic               cfg_wr_i,
  output logic               cfg_ready_o,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic [LA_W-1:0]    cfg_node_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [D_WIDTH-1:0] cfg_data_i,
  input  logic               cfg_vld_i,
  input  logic               stat_clr_i,
  output logic [31:0]        stat_lookups_o,
  output logic [31:0]        stat_matches_o
);
  localparam int NB = FANOUT ** STAGES;

  typedef enum logic {INIT, RUN} state_t;
  state_t          state;
  logic [LA_W-1:0] init_cnt;
  logic            adv;
  logic            lookup_fire;
  logic            cfg_fire;

  assign adv            = !(res_valid_o && !res_ready_i);
  assign lookup_ready_o = (state == RUN) && adv;
  assign lookup_fire    = lookup_valid_i && lookup_ready_o;
  assign cfg_fire       = cfg_wr_i && cfg_ready_o && !rst_i;

  // INIT sweeps one leaf bucket per cycle; the table opens once the last bucket is cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= INIT;
      init_cnt    <= '0;
      cfg_ready_o <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LA_W'(NB - 1)) begin
        state       <= RUN;
        cfg_ready_o <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_lvl
    logic [FANOUT-2:0][D_WIDTH-1:0] key [NB];
    logic               vld;
    logic [LA_W-1:0]    node;
    logic [D_WIDTH-1:0] dat;
    logic               vld_in;
    logic [LA_W-1:0]    node_in;
    logic [D_WIDTH-1:0] dat_in;
    logic [FW-1:0]      child;

    if (g == 0) begin : g_in
      assign vld_in  = lookup_fire;
      assign node_in = '0;
      assign dat_in  = lookup_data_i;
    end else begin : g_in
      assign vld_in  = g_lvl[g-1].vld;
      assign node_in = g_lvl[g-1].node;
      assign dat_in  = g_lvl[g-1].dat;
    end

    always_comb begin
      child = '0;
      for (int k = 0; k < FANOUT - 1; k++)
        if (dat_in >= key[node_in][k]) child = child + 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld <= 1'b0;
      end else if (adv) begin
        vld  <= vld_in;
        node <= (node_in << FW) | LA_W'(child);
        dat  <= dat_in;
      end
    end

    // Nodes beyond FANOUT^g do not exist at this level, so such writes are dropped.
    always_ff @(posedge clk_i) begin
      if (cfg_fire && cfg_sel_i == SEL_W'(g) && cfg_node_i < LA_W'(FANOUT ** g))
        for (int k = 0; k < FANOUT - 1; k++)
          if (cfg_idx_i == IDX_W'(k)) key[cfg_node_i][k] <= cfg_data_i;
    end
  end

  logic [D_CNT-1:0][D_WIDTH-1:0] leaf_dat [NB];
  logic [D_CNT-1:0]              leaf_ok  [NB];

  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      leaf_ok[init_cnt] <= '0;
    end else if (cfg_fire && cfg_sel_i == SEL_W'(STAGES)) begin
      for (int j = 0; j < D_CNT; j++)
        if (cfg_idx_i == IDX_W'(j)) begin
          leaf_dat[cfg_node_i][j] <= cfg_data_i;
          leaf_ok[cfg_node_i][j]  <= cfg_vld_i;
        end
    end
  end

  logic [LA_W-1:0]    bucket;
  logic [D_WIDTH-1:0] leaf_key;
  logic               hit;
  logic [DW-1:0]      hit_idx;

  assign bucket   = g_lvl[STAGES-1].node;
  assign leaf_key = g_lvl[STAGES-1].dat;

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = D_CNT - 1; j >= 0; j--)
      if (leaf_ok[bucket][j] && leaf_dat[bucket][j] == leaf_key) begin
        hit     = 1'b1;
        hit_idx = DW'(j);
      end
  end

  logic               lf_vld;
  logic               lf_match;
  logic [RA_W-1:0]    lf_addr;
  logic [D_WIDTH-1:0] lf_dat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lf_vld <= 1'b0;
    end else if (adv) begin
      lf_vld   <= g_lvl[STAGES-1].vld;
      lf_match <= hit;
      lf_addr  <= {bucket, hit_idx};
      lf_dat   <= leaf_key;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_match_o <= 1'b0;
      res_addr_o  <= '0;
      res_data_o  <= '0;
    end else if (adv) begin
      res_valid_o <= lf_vld;
      res_match_o <= lf_match;
      res_addr_o  <= lf_addr;
      res_data_o  <= lf_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i)
      stat_lookups_o <= '0;
    else if (lookup_fire && stat_lookups_o != '1)
      stat_lookups_o <= stat_lookups_o + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i)
      stat_matches_o <= '0;
    else if (res_valid_o && res_ready_i && res_match_o && stat_matches_o != '1)
      stat_matches_o <= stat_matches_o + 1'b1;
  end

endmodule

// File: tb/tb_qtree_search.sv
// Bench for qtree_search: scenario tasks checked against a tree model computed by plain arithmetic.
`timescale 1ns/1ps
module tb_qtree_search;
  localparam int STAGES = 3, FANOUT = 4, D_WIDTH = 16, D_CNT = 4;
  localparam int LA_W = 6, RA_W = 8, SEL_W = 2, IDX_W = 2, NB = 64;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               lookup_valid_i;
  logic               lookup_ready_o;
  logic [D_WIDTH-1:0] lookup_data_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic               res_match_o;
  logic [RA_W-1:0]    res_addr_o;
  logic [D_WIDTH-1:0] res_data_o;
  logic               cfg_wr_i;
  logic               cfg_ready_o;
  logic [SEL_W-1:0]   cfg_sel_i;
  logic [LA_W-1:0]    cfg_node_i;
  logic [IDX_W-1:0]   cfg_idx_i;
  logic [D_WIDTH-1:0] cfg_data_i;
  logic               cfg_vld_i;
  logic               stat_clr_i;
  logic [31:0]        stat_lookups_o;
  logic [31:0]        stat_matches_o;

  qtree_search #(.STAGES(STAGES), .FANOUT(FANOUT), .D_WIDTH(D_WIDTH), .D_CNT(D_CNT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o), .lookup_data_i(lookup_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_match_o(res_match_o),
    .res_addr_o(res_addr_o), .res_data_o(res_data_o),
    .cfg_wr_i(cfg_wr_i), .cfg_ready_o(cfg_ready_o), .cfg_sel_i(cfg_sel_i), .cfg_node_i(cfg_node_i),
    .cfg_idx_i(cfg_idx_i), .cfg_data_i(cfg_data_i), .cfg_vld_i(cfg_vld_i),
    .stat_clr_i(stat_clr_i), .stat_lookups_o(stat_lookups_o), .stat_matches_o(stat_matches_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  int unsigned mkey [STAGES][NB][FANOUT-1];
  logic [15:0] mdat [NB][D_CNT];
  bit          mok  [NB][D_CNT];
  int          exp_lookups = 0;
  int          exp_matches = 0;
  logic [15:0] pool [$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int route(input logic [15:0] d);
    int node, c;
    node = 0;
    for (int g = 0; g < STAGES; g++) begin
      c = 0;
      for (int k = 0; k < FANOUT - 1; k++) if (int'(d) >= int'(mkey[g][node][k])) c++;
      node = node * FANOUT + c;
    end
    return node;
  endfunction

  function automatic void predict(input logic [15:0] d, output logic m, output logic [RA_W-1:0] a);
    int b, idx;
    b = route(d);
    idx = 0;
    m = 1'b0;
    for (int j = D_CNT - 1; j >= 0; j--)
      if (mok[b][j] && mdat[b][j] == d) begin m = 1'b1; idx = j; end
    a = RA_W'(b * D_CNT + idx);
  endfunction

  function automatic void clear_model_leaves();
    for (int b = 0; b < NB; b++) for (int j = 0; j < D_CNT; j++) mok[b][j] = 1'b0;
  endfunction

  task automatic cfg_write(input int sel, input int node, input int idx, input logic [15:0] data, input bit vld);
    cfg_wr_i = 1'b1; cfg_sel_i = SEL_W'(sel); cfg_node_i = LA_W'(node);
    cfg_idx_i = IDX_W'(idx); cfg_data_i = data; cfg_vld_i = vld;
    tick();
    cfg_wr_i = 1'b0;
    if (sel < STAGES) mkey[sel][node][idx] = data;
    else begin mdat[node][idx] = data; mok[node][idx] = vld; end
  endtask

  task automatic lookup_one(input logic [15:0] d, output logic m, output logic [RA_W-1:0] a,
                            output logic [15:0] dat, output int lat,
                            output logic em, output logic [RA_W-1:0] ea);
    int n;
    res_ready_i = 1'b1;
    lookup_data_i = d;
    lookup_valid_i = 1'b1;
    n = 0;
    while (!lookup_ready_o && n < 200) begin tick(); n++; end
    predict(d, em, ea);
    tick();
    lookup_valid_i = 1'b0;
    exp_lookups++;
    if (em) exp_matches++;
    lat = 1;
    while (!res_valid_o && lat < 30) begin tick(); lat++; end
    m = res_match_o; a = res_addr_o; dat = res_data_o;
    tick();
  endtask

  task automatic test_reset();
    int n_at;
    logic r, c;
    rst_i = 1'b1;
    repeat (3) tick();
    tests_run++; if (res_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_res_valid: got %b want 0", res_valid_o); end
    tests_run++; if (res_match_o !== 1'b0) begin tests_failed++; $display("FAIL rst_res_match: got %b want 0", res_match_o); end
    tests_run++; if (res_addr_o !== 8'h00) begin tests_failed++; $display("FAIL rst_res_addr: got %h want 00", res_addr_o); end
    tests_run++; if (res_data_o !== 16'h0000) begin tests_failed++; $display("FAIL rst_res_data: got %h want 0000", res_data_o); end
    tests_run++; if (stat_lookups_o !== 32'd0 || stat_matches_o !== 32'd0) begin
      tests_failed++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_lookups_o, stat_matches_o); end
    tests_run++; if (lookup_ready_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL rst_ready: got %b/%b want 0/0", lookup_ready_o, cfg_ready_o); end
    clear_model_leaves();
    // A leaf write held through INIT must never be taken.
    cfg_wr_i = 1'b1; cfg_sel_i = SEL_W'(STAGES); cfg_node_i = '0; cfg_idx_i = '0;
    cfg_data_i = 16'h0000; cfg_vld_i = 1'b1;
    rst_i = 1'b0;
    n_at = 0; r = 1'b0; c = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (lookup_ready_o || cfg_ready_o) begin n_at = n; r = lookup_ready_o; c = cfg_ready_o; break; end
    end
    cfg_wr_i = 1'b0;
    tests_run++; if (n_at !== 64) begin tests_failed++; $display("FAIL init_cycles: got %0d want 64", n_at); end
    tests_run++; if (r !== 1'b1 || c !== 1'b1) begin
      tests_failed++; $display("FAIL init_ready_pair: got %b/%b want 1/1", r, c); end
  endtask

  task automatic test_program();
    for (int g = 0; g < STAGES; g++)
      for (int node = 0; node < FANOUT ** g; node++) begin
        cfg_write(g, node, 0, 16'h4000, 1'b0);
        cfg_write(g, node, 1, 16'h8000, 1'b0);
        cfg_write(g, node, 2, 16'hC000, 1'b0);
      end
    cfg_write(STAGES, 63, 2, 16'hF123, 1'b1);
  endtask

  task automatic test_hit_miss();
    logic m, em; logic [RA_W-1:0] a, ea; logic [15:0] dat; int lat;
    lookup_one(16'hF123, m, a, dat, lat, em, ea);
    tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL hit_latency: got %0d want 5", lat); end
    tests_run++; if (m !== 1'b1) begin tests_failed++; $display("FAIL hit_match: got %b want 1", m); end
    tests_run++; if (a !== 8'hFE) begin tests_failed++; $display("FAIL hit_addr: got %h want fe", a); end
    tests_run++; if (dat !== 16'hF123) begin tests_failed++; $display("FAIL hit_data: got %h want f123", dat); end
    lookup_one(16'hF124, m, a, dat, lat, em, ea);
    tests_run++; if (m !== 1'b0) begin tests_failed++; $display("FAIL miss_match: got %b want 0", m); end
    tests_run++; if (a !== 8'hFC) begin tests_failed++; $display("FAIL miss_addr: got %h want fc", a); end
    tests_run++; if (dat !== 16'hF124) begin tests_failed++; $display("FAIL miss_data: got %h want f124", dat); end
    lookup_one(16'h0000, m, a, dat, lat, em, ea);
    tests_run++; if (m !== 1'b0 || a !== 8'h00) begin
      tests_failed++; $display("FAIL init_write_ignored: got match=%b addr=%h want 0/00", m, a); end
    tests_run++; if (stat_lookups_o !== 32'(exp_lookups) || stat_matches_o !== 32'(exp_matches)) begin
      tests_failed++; $display("FAIL stats_after_hit: got %0d/%0d want %0d/%0d",
                               stat_lookups_o, stat_matches_o, exp_lookups, exp_matches); end
  endtask

  task automatic test_same_cycle_write();
    logic m, em; logic [RA_W-1:0] a, ea; logic [15:0] dat; int lat, n;
    res_ready_i = 1'b1;
    lookup_data_i = 16'hF123; lookup_valid_i = 1'b1;
    tick();
    lookup_valid_i = 1'b0;
    exp_lookups++; exp_matches++;
    tick(); tick();
    // This write lands on the same edge that registers the leaf compare for the lookup above.
    cfg_write(STAGES, 63, 2, 16'hF123, 1'b0);
    n = 0;
    while (!res_valid_o && n < 30) begin tick(); n++; end
    tests_run++; if (res_valid_o !== 1'b1 || res_match_o !== 1'b1 || res_addr_o !== 8'hFE) begin
      tests_failed++; $display("FAIL same_cycle_old_value: got v=%b m=%b a=%h want 1/1/fe",
                               res_valid_o, res_match_o, res_addr_o); end
    tick();
    lookup_one(16'hF123, m, a, dat, lat, em, ea);
    tests_run++; if (m !== 1'b0 || a !== 8'hFC) begin
      tests_failed++; $display("FAIL after_clear: got m=%b a=%h want 0/fc", m, a); end
  endtask

  task automatic test_stall_stat_clr();
    int n;
    logic [RA_W-1:0] a0; logic [15:0] d0;
    cfg_write(STAGES, 63, 2, 16'hF123, 1'b1);
    res_ready_i = 1'b0;
    lookup_data_i = 16'hF123; lookup_valid_i = 1'b1;
    tick();
    lookup_valid_i = 1'b0;
    exp_lookups++;
    n = 0;
    while (!res_valid_o && n < 30) begin tick(); n++; end
    tests_run++; if (res_valid_o !== 1'b1 || res_match_o !== 1'b1) begin
      tests_failed++; $display("FAIL stall_result: got v=%b m=%b want 1/1", res_valid_o, res_match_o); end
    a0 = res_addr_o; d0 = res_data_o;
    tick();
    tests_run++; if (res_valid_o !== 1'b1 || res_addr_o !== a0 || res_data_o !== d0 || lookup_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL stall_freeze: got v=%b a=%h d=%h rdy=%b want 1/%h/%h/0",
                               res_valid_o, res_addr_o, res_data_o, lookup_ready_o, a0, d0); end
    tests_run++; if (stat_matches_o !== 32'(exp_matches) || stat_lookups_o !== 32'(exp_lookups)) begin
      tests_failed++; $display("FAIL stats_pre_clr: got %0d/%0d want %0d/%0d",
                               stat_lookups_o, stat_matches_o, exp_lookups, exp_matches); end
    stat_clr_i = 1'b1; res_ready_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    exp_lookups = 0; exp_matches = 0;
    tests_run++; if (stat_matches_o !== 32'd0 || stat_lookups_o !== 32'd0) begin
      tests_failed++; $display("FAIL stat_clr_priority: got %0d/%0d want 0/0", stat_lookups_o, stat_matches_o); end
    tests_run++; if (res_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL stall_release: got v=%b want 0", res_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qd [$]; logic qm [$]; logic [RA_W-1:0] qa [$];
    logic em, acc, hs, stray;
    logic [RA_W-1:0] ea;
    logic [15:0] d, pd;
    int sent, got, cyc, a, b, c;
    for (int g = 1; g < STAGES; g++)
      for (int node = 0; node < FANOUT ** g; node++) begin
        a = $urandom_range(0, 16'h5555);
        b = a + $urandom_range(1, 16'h5555);
        c = b + $urandom_range(1, 16'h5555);
        cfg_write(g, node, 0, 16'(a), 1'b0);
        cfg_write(g, node, 1, 16'(b), 1'b0);
        cfg_write(g, node, 2, 16'(c), 1'b0);
      end
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      pool.push_back(d);
      cfg_write(STAGES, route(d), $urandom_range(0, D_CNT - 1), d, $urandom_range(0, 3) != 0);
    end
    sent = 0; got = 0; cyc = 0;
    res_ready_i = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_data_i = pool[$urandom_range(0, pool.size() - 1)];
    while (got < 20 && cyc < 1000) begin
      @(negedge clk_i);
      acc = lookup_valid_i && lookup_ready_o;
      hs = res_valid_o && res_ready_i;
      if (acc) begin
        predict(lookup_data_i, em, ea);
        qd.push_back(lookup_data_i); qm.push_back(em); qa.push_back(ea);
        sent++;
      end
      if (hs) begin
        if (qd.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL b2b_extra_result: got data=%h with no lookup outstanding", res_data_o);
        end else begin
          pd = qd.pop_front(); em = qm.pop_front(); ea = qa.pop_front();
          if (em) exp_matches++;
          tests_run++; if (res_data_o !== pd) begin tests_failed++;
            $display("FAIL b2b_data #%0d: got %h want %h", got, res_data_o, pd); end
          tests_run++; if (res_match_o !== em) begin tests_failed++;
            $display("FAIL b2b_match #%0d: got %b want %b", got, res_match_o, em); end
          tests_run++; if (res_addr_o !== ea) begin tests_failed++;
            $display("FAIL b2b_addr #%0d: got %h want %h", got, res_addr_o, ea); end
        end
        got++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
      if (acc) begin
        if (sent < 20)
          lookup_data_i = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, pool.size() - 1)]
                                                       : 16'($urandom_range(0, 16'hFFFF));
        else
          lookup_valid_i = 1'b0;
      end
      res_ready_i = 1'($urandom_range(0, 1));
    end
    lookup_valid_i = 1'b0;
    res_ready_i = 1'b1;
    tests_run++; if (got !== 20 || sent !== 20) begin tests_failed++;
      $display("FAIL b2b_count: got %0d results from %0d lookups want 20/20", got, sent); end
    stray = 1'b0;
    repeat (10) begin tick(); if (res_valid_o) stray = 1'b1; end
    tests_run++; if (stray !== 1'b0) begin tests_failed++; $display("FAIL b2b_stray_valid: got %b want 0", stray); end
    tests_run++; if (stat_lookups_o !== 32'd20) begin tests_failed++;
      $display("FAIL b2b_stat_lookups: got %0d want 20", stat_lookups_o); end
    tests_run++; if (stat_matches_o !== 32'(exp_matches)) begin tests_failed++;
      $display("FAIL b2b_stat_matches: got %0d want %0d", stat_matches_o, exp_matches); end
  endtask

  task automatic test_reset_inflight();
    logic m, em, saw_valid; logic [RA_W-1:0] a, ea; logic [15:0] dat, probe; int lat, first;
    res_ready_i = 1'b1;
    lookup_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lookup_data_i = pool[i];
      tick();
    end
    lookup_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_model_leaves();
    exp_lookups = 0; exp_matches = 0;
    tests_run++; if (stat_lookups_o !== 32'd0 || res_valid_o !== 1'b0) begin tests_failed++;
      $display("FAIL midrst_state: got lookups=%0d v=%b want 0/0", stat_lookups_o, res_valid_o); end
    saw_valid = 1'b0; first = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (res_valid_o) saw_valid = 1'b1;
      if (lookup_ready_o && first == 0) first = n;
    end
    tests_run++; if (saw_valid !== 1'b0) begin tests_failed++;
      $display("FAIL midrst_no_result: got valid seen=%b want 0", saw_valid); end
    tests_run++; if (first !== 64) begin tests_failed++; $display("FAIL midrst_init_cycles: got %0d want 64", first); end
    probe = pool[0];
    for (int i = 0; i < pool.size(); i++) if (mdat[route(pool[i])][0] == pool[i]) probe = pool[i];
    lookup_one(probe, m, a, dat, lat, em, ea);
    tests_run++; if (m !== 1'b0 || a !== ea) begin tests_failed++;
      $display("FAIL midrst_leaves_cleared: got m=%b a=%h want 0/%h", m, a, ea); end
  endtask

  initial begin
    rst_i = 1'b1; lookup_valid_i = 1'b0; lookup_data_i = '0; res_ready_i = 1'b1;
    cfg_wr_i = 1'b0; cfg_sel_i = '0; cfg_node_i = '0; cfg_idx_i = '0; cfg_data_i = '0; cfg_vld_i = 1'b0;
    stat_clr_i = 1'b0;
    test_reset();
    test_program();
    test_hit_miss();
    test_same_cycle_write();
    test_stall_stat_clr();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
